// File: rtl/conv2d_window_gen.sv
// conv2d_window_gen
// Walks an image stored in a synchronous memory and streams the K x K
// neighbourhood (tap) of every output pixel.
//
// Visiting order:
//   - Output pixels are visited in row-major order.
//   - Within each window, tap column tc is the outer loop and tap row tr is
//     the inner loop.
//
// Each tap is issued as a memory read and presented on px_out one cycle
// later.
//
// Build option CONV2D_SAME_PAD_EN:
//   - Defined: "same" convolution. The output is rows x cols, and taps that
//     fall outside the image read as zero.
//   - Undefined (default): "valid" convolution. The output is
//     (rows-K+1) x (cols-K+1).
//
// Ports:
//   clk, rst           clock; synchronous active-high reset
//   start              begins one image pass while idle
//   rows, cols         image dimensions, captured when start is accepted
//   rd_addr, rd_en     read port to the image memory (linear address r*cols+c)
//   rd_data            read data, valid the cycle after rd_en and held until
//                      the next rd_en
//   px_out, px_valid   tap stream; px_last marks the final tap of a window
//   out_ready          tap-stream backpressure
//   wr_addr, wr_en     output-pixel index, strobed with the final tap of each
//                      window
//   busy, done         pass in progress; single-cycle completion pulse
module conv2d_window_gen #(
   parameter int ADDR_W = 17,
   parameter int DATA_W = 12,
   parameter int DIM_W  = 8,
   parameter int K      = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [DIM_W-1:0]  rows,
   input  logic [DIM_W-1:0]  cols,
   output logic [ADDR_W-1:0] rd_addr,
   output logic              rd_en,
   input  logic [DATA_W-1:0] rd_data,
   output logic [DATA_W-1:0] px_out,
   output logic              px_valid,
   output logic              px_last,
   input  logic              out_ready,
   output logic [ADDR_W-1:0] wr_addr,
   output logic              wr_en,
   output logic              busy,
   output logic              done
);

   // Tap counters only need to reach K-1 <= 6.
   localparam int TW = 3;

`ifdef CONV2D_SAME_PAD_EN
   localparam bit SAME_PAD = 1'b1;
   localparam int P        = (K - 1) / 2;
`else
   localparam bit SAME_PAD = 1'b0;
   localparam int P        = 0;
`endif

   // The linear address is formed at full product width before truncation.
   localparam int LIN_W = (2 * DIM_W + 4 > ADDR_W) ? 2 * DIM_W + 4 : ADDR_W;
   localparam logic [DIM_W-1:0] KM1 = DIM_W'(K - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DRAIN,
      S_DONE
   } state_t;

   state_t             state_q, state_d;
   logic [DIM_W-1:0]   rows_q, rows_d, cols_q, cols_d;
   logic [DIM_W-1:0]   orows_q, orows_d, ocols_q, ocols_d;
   logic [DIM_W-1:0]   orow_q, orow_d, ocol_q, ocol_d;
   logic [TW-1:0]      tr_q, tr_d, tc_q, tc_d;
   logic [ADDR_W-1:0]  out_idx_q, out_idx_d;
   logic [ADDR_W-1:0]  wr_addr_q, wr_addr_d;
   logic               px_valid_q, px_valid_d;
   logic               pad_q, pad_d;
   logic               tap_last_q, tap_last_d;

   logic [DIM_W-1:0]         orows_in, ocols_in;
   logic signed [DIM_W+1:0]  tap_r, tap_c;
   logic signed [LIN_W-1:0]  tap_r_x, tap_c_x, cols_x, lin;
   logic                     in_range;
   logic                     tr_last, tc_last, ocol_last, orow_last;
   logic                     win_last, pass_last;
   logic                     stall, accept, issue;

   // Output dimensions implied by the dimensions presented with start.
   always_comb begin
      orows_in = '0;
      ocols_in = '0;
      if (SAME_PAD) begin
         orows_in = rows;
         ocols_in = cols;
      end else begin
         orows_in = (rows > KM1) ? rows - KM1 : '0;
         ocols_in = (cols > KM1) ? cols - KM1 : '0;
      end
   end

   // Tap coordinates (signed) and their linear memory address.
   always_comb begin
      tap_r = $signed({2'b00, orow_q}) + $signed((DIM_W + 2)'(tr_q))
              - $signed((DIM_W + 2)'(P));
      tap_c = $signed({2'b00, ocol_q}) + $signed((DIM_W + 2)'(tc_q))
              - $signed((DIM_W + 2)'(P));
      tap_r_x = LIN_W'(tap_r);
      tap_c_x = LIN_W'(tap_c);
      cols_x  = LIN_W'({2'b00, cols_q});
      lin     = tap_r_x * cols_x + tap_c_x;
      in_range = !SAME_PAD ||
                 (!tap_r[DIM_W+1] && (tap_r < $signed({2'b00, rows_q})) &&
                  !tap_c[DIM_W+1] && (tap_c < $signed({2'b00, cols_q})));
   end

   always_comb begin
      tr_last   = (tr_q == TW'(K - 1));
      tc_last   = (tc_q == TW'(K - 1));
      ocol_last = (ocol_q == ocols_q - DIM_W'(1));
      orow_last = (orow_q == orows_q - DIM_W'(1));
      win_last  = tr_last && tc_last;
      pass_last = win_last && ocol_last && orow_last;
      // A stalled tap freezes the whole issue pipeline. No read is made while
      // stalled, so the memory keeps holding the pending tap's data.
      stall     = px_valid_q && !out_ready;
      accept    = px_valid_q && out_ready;
      issue     = (state_q == S_RUN) && !stall;
   end

   always_comb begin
      state_d    = state_q;
      rows_d     = rows_q;
      cols_d     = cols_q;
      orows_d    = orows_q;
      ocols_d    = ocols_q;
      orow_d     = orow_q;
      ocol_d     = ocol_q;
      tr_d       = tr_q;
      tc_d       = tc_q;
      out_idx_d  = out_idx_q;
      wr_addr_d  = wr_addr_q;
      px_valid_d = px_valid_q;
      pad_d      = pad_q;
      tap_last_d = tap_last_q;
      case (state_q)
         S_IDLE: begin
            px_valid_d = 1'b0;
            if (start) begin
               rows_d    = rows;
               cols_d    = cols;
               orows_d   = orows_in;
               ocols_d   = ocols_in;
               orow_d    = '0;
               ocol_d    = '0;
               tr_d      = '0;
               tc_d      = '0;
               out_idx_d = '0;
               state_d   = ((orows_in == '0) || (ocols_in == '0)) ? S_DONE : S_RUN;
            end
         end
         S_RUN: begin
            if (issue) begin
               px_valid_d = 1'b1;
               pad_d      = !in_range;
               tap_last_d = win_last;
               if (win_last) begin
                  wr_addr_d = out_idx_q;
                  out_idx_d = out_idx_q + ADDR_W'(1);
               end
               if (!tr_last) begin
                  tr_d = tr_q + TW'(1);
               end else begin
                  tr_d = '0;
                  if (!tc_last) begin
                     tc_d = tc_q + TW'(1);
                  end else begin
                     tc_d = '0;
                     if (!ocol_last) begin
                        ocol_d = ocol_q + DIM_W'(1);
                     end else begin
                        ocol_d = '0;
                        orow_d = orow_q + DIM_W'(1);
                     end
                  end
               end
               if (pass_last) begin
                  state_d = S_DRAIN;
               end
            end
         end
         S_DRAIN: begin
            // Only the final tap of the pass can be pending here.
            if (accept) begin
               px_valid_d = 1'b0;
               state_d    = S_DONE;
            end
         end
         S_DONE: begin
            px_valid_d = 1'b0;
            state_d    = S_IDLE;
         end
         default: begin
            px_valid_d = 1'b0;
            state_d    = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         rows_q     <= '0;
         cols_q     <= '0;
         orows_q    <= '0;
         ocols_q    <= '0;
         orow_q     <= '0;
         ocol_q     <= '0;
         tr_q       <= '0;
         tc_q       <= '0;
         out_idx_q  <= '0;
         wr_addr_q  <= '0;
         px_valid_q <= 1'b0;
         pad_q      <= 1'b0;
         tap_last_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         rows_q     <= rows_d;
         cols_q     <= cols_d;
         orows_q    <= orows_d;
         ocols_q    <= ocols_d;
         orow_q     <= orow_d;
         ocol_q     <= ocol_d;
         tr_q       <= tr_d;
         tc_q       <= tc_d;
         out_idx_q  <= out_idx_d;
         wr_addr_q  <= wr_addr_d;
         px_valid_q <= px_valid_d;
         pad_q      <= pad_d;
         tap_last_q <= tap_last_d;
      end
   end

   // Addresses are forced to zero whenever their strobe is low, so idle and
   // reset outputs are fully quiet.
   always_comb begin
      rd_en    = issue && in_range;
      rd_addr  = rd_en ? lin[ADDR_W-1:0] : '0;
      px_valid = px_valid_q;
      px_out   = (px_valid_q && !pad_q) ? rd_data : '0;
      px_last  = accept && tap_last_q;
      wr_en    = accept && tap_last_q;
      wr_addr  = wr_en ? wr_addr_q : '0;
      busy     = (state_q != S_IDLE);
      done     = (state_q == S_DONE);
   end

endmodule

// File: doc/conv2d_window_gen.md
CONV2D_WINDOW_GEN -- requirements
Module: conv2d_window_gen

Interface
REQ-001 SHALL have parameter ADDR_W, default 17, memory address width.
REQ-002 SHALL have parameter DATA_W, default 12, pixel width.
REQ-003 SHALL have parameter DIM_W, default 8, width of the image-dimension inputs.
REQ-004 SHALL have parameter K, default 3, filter size; odd, 3..7.
REQ-005 SHALL have clk  in  1  clock; rst  in  1  reset, synchronous, active-high.
REQ-006 SHALL have start  in  1  begins one image pass when in IDLE.
REQ-007 SHALL have rows, cols  in  DIM_W each  image dimensions, sampled on accepted start.
REQ-008 SHALL have rd_addr  out  ADDR_W, rd_en  out  1, rd_data  in  DATA_W  sync memory port; data valid 1 cycle after rd_en and held until the next rd_en.
REQ-009 SHALL have px_out  out  DATA_W, px_valid  out  1, px_last  out  1, out_ready  in  1  tap stream with backpressure.
REQ-010 SHALL have wr_addr  out  ADDR_W, wr_en  out  1  output-pixel index and strobe.
REQ-011 SHALL have busy  out  1 and done  out  1 (single-cycle pulse).

Function
REQ-012 SHALL implement states IDLE, RUN, DRAIN, DONE; IDLE->RUN on start; RUN->DRAIN after the last tap is issued; DRAIN->DONE when the last tap is accepted; DONE->IDLE next cycle.
REQ-013 SHALL visit output pixels (orow, ocol) row-major; per output, K*K taps, tap column tc outer and tap row tr inner, each 0..K-1.
REQ-014 SHALL compute tap coordinates as r = orow+tr-P, c = ocol+tc-P in signed DIM_W+2 bits; rd_addr = r*cols+c truncated to ADDR_W.
REQ-015 SHALL issue one tap per unstalled cycle; in-range taps assert rd_en; out-of-range taps keep rd_en low and yield px_out = 0.
REQ-016 SHALL present each tap on px_out/px_valid exactly one cycle after issue.
REQ-017 SHALL stall when px_valid=1 and out_ready=0: counters, rd_en and px_out frozen, no tap lost or duplicated.
REQ-018 SHALL assert px_last, and wr_en with wr_addr = orow*ocols+ocol, on the cycle the final tap of a window is valid and accepted.
REQ-019 SHALL pulse done one cycle after the final tap is accepted; busy high from the cycle after start through the DONE cycle.
REQ-020 SHALL ignore start while busy; rows/cols changes during a pass have no effect.
REQ-021 SHALL go IDLE->DONE directly, emitting no taps, when the output size is zero (rows=0, cols=0, or valid-mode dimensions below K).

Reset
REQ-022 SHALL on rst clear state to IDLE and drive rd_en, px_valid, px_last, wr_en, busy, done to 0 and rd_addr, wr_addr, px_out to 0.
REQ-023 SHALL on rst mid-pass abandon the pass immediately with no further taps or wr_en; the next start begins a fresh pass from output 0.

Configuration
REQ-024 SHALL, with CONV2D_SAME_PAD_EN defined, use P=(K-1)/2 and output size rows x cols, with zero padding for out-of-range taps.
REQ-025 SHALL, without CONV2D_SAME_PAD_EN, use P=0 and output size (rows-K+1) x (cols-K+1); no tap is ever out of range.

Verification
REQ-026 SAME_PAD, K=3, 5x5, out_ready=1 -> first window rd_en pattern 0,0,0,0,1,1,0,1,1 with addresses 0,5,1,6; 225 px_valid, 25 wr_en (wr_addr 0..24), one done.
REQ-027 Valid mode, K=3, 5x5 -> first window addresses 0,5,10,1,6,11,2,7,12; 81 px_valid; last wr_addr 8.
REQ-028 out_ready low 3 cycles at tap 4 of window 0 -> px_out held constant, 225 taps total, sequence unchanged.
REQ-029 rst asserted at tap 50 -> all outputs 0 next cycle; a new start yields the full REQ-026 sequence.
REQ-030 start with rows=0 -> done within 2 cycles, no px_valid; start pulsed while busy -> ignored, one done only.
